// File: rtl/mem_loader.sv
// Boot-time program loader. It takes a valid/ready byte stream, builds
// little-endian 32-bit words and writes them to consecutive RAM words.
// The core is held in reset until the whole image has been written.
// The stream is a 4-byte LE word count N, then N words of 4 LE bytes each.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to add one trailing checksum
// byte. That byte is the XOR of all data bytes, and a mismatch aborts the load.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 2057
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] StHdr   = 3'd0;
  localparam logic [2:0] StData  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StFinal = StCsum;
`else
  localparam logic [2:0] StFinal = StDone;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;
  logic        core_rst_q, core_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [31:0] count_next;
  logic [31:0] word_next;

  assign in_ready   = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
  assign accept     = in_valid & in_ready;
  // First byte of the stream ends up in bits 7:0 after four shifts.
  assign count_next = {in_data, count_q[31:8]};
  assign word_next  = word_cnt_q + 32'd1;

  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign mem_we   = mem_we_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign error    = error_q;

  // Next-state logic for the loader FSM and its datapath
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_we_d   = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      StHdr: begin
        if (accept) begin
          count_d    = count_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (count_next == 32'd0) begin
              state_d = StFinal;
            end else if (count_next > 32'(MAX_WORDS)) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          mem_wd_d   = {in_data, mem_wd_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d    = StWrite;
            mem_we_d   = 1'b1;
            mem_addr_d = BASE_ADDR + (word_cnt_q << 2);
          end
        end
      end
      StWrite: begin
        // The write pulse lasts exactly this cycle, and no byte is taken here.
        word_cnt_d = word_next;
        state_d    = (word_next == count_q) ? StFinal : StData;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: begin
        // StDone and StErr are terminal. Only rst leaves them.
        state_d = state_q;
      end
    endcase

    // Status flags are sticky and register on the edge that enters the terminal state.
    done_d     = done_q | (state_d == StDone);
    core_rst_d = core_rst_q & (state_d != StDone);
    error_d    = error_q | (state_d == StErr);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHdr;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      count_q    <= 32'd0;
      mem_addr_q <= BASE_ADDR;
      mem_wd_q   <= 32'd0;
      mem_we_q   <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_we_q   <= mem_we_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
